// File: rtl/bch_31_pkg.sv
// rtl/bch_31_pkg.sv - BCH(31,21) code constants and GF(2^5) arithmetic helpers
package bch_31_pkg;

    localparam int N  = 31;
    localparam int K  = 21;
    localparam int T  = 2;
    localparam int NK = N - K;
    localparam logic [10:0] GEN_POLY = 11'h769;

    // alpha^i for i = 0..31 under x^5+x^2+1; the last entry wraps back to alpha^0
    localparam logic [4:0] GF_EXP [0:31] = '{
        5'd1,  5'd2,  5'd4,  5'd8,  5'd16, 5'd5,  5'd10, 5'd20,
        5'd13, 5'd26, 5'd17, 5'd7,  5'd14, 5'd28, 5'd29, 5'd31,
        5'd27, 5'd19, 5'd3,  5'd6,  5'd12, 5'd24, 5'd21, 5'd15,
        5'd30, 5'd25, 5'd23, 5'd11, 5'd22, 5'd9,  5'd18, 5'd1
    };

    // Discrete log; the log of 0 is undefined, so entry 0 is never looked up
    localparam logic [4:0] GF_LOG [0:31] = '{
        5'd0,  5'd0,  5'd1,  5'd18, 5'd2,  5'd5,  5'd19, 5'd11,
        5'd3,  5'd29, 5'd6,  5'd27, 5'd20, 5'd8,  5'd12, 5'd23,
        5'd4,  5'd10, 5'd30, 5'd17, 5'd7,  5'd22, 5'd28, 5'd26,
        5'd21, 5'd25, 5'd9,  5'd16, 5'd13, 5'd14, 5'd24, 5'd15
    };

    localparam logic [4:0] GF_INV [0:31] = '{
        5'd0,  5'd1,  5'd18, 5'd28, 5'd9,  5'd23, 5'd14, 5'd12,
        5'd22, 5'd4,  5'd25, 5'd16, 5'd7,  5'd15, 5'd6,  5'd13,
        5'd11, 5'd24, 5'd2,  5'd29, 5'd30, 5'd26, 5'd8,  5'd5,
        5'd17, 5'd10, 5'd21, 5'd31, 5'd3,  5'd19, 5'd20, 5'd27
    };

    function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
        logic [8:0] p;
        p = '0;
        for (int i = 0; i < 5; i++) begin
            if (b[3'(i)]) p = p ^ (9'(a) << i);
        end
        for (int i = 8; i >= 5; i--) begin
            if (p[4'(i)]) p = p ^ (9'h025 << (i - 5));
        end
        return p[4:0];
    endfunction

    function automatic logic [4:0] gf_inv(input logic [4:0] a);
        return GF_INV[a];
    endfunction

    function automatic logic [4:0] gf_pow3(input logic [4:0] a);
        return gf_mul(a, gf_mul(a, a));
    endfunction

endpackage

// File: rtl/bch_31_21_codec_if.sv
// rtl/bch_31_21_codec_if.sv - encoder and decoder stream signals of the BCH(31,21) codec
interface bch_31_21_codec_if;
    import bch_31_pkg::*;

    logic         enc_valid_i;
    logic [K-1:0] msg_i;
    logic         enc_valid_o;
    logic [N-1:0] codeword_o;
    logic         dec_valid_i;
    logic [N-1:0] rx_codeword_i;
    logic         dec_valid_o;
    logic [N-1:0] corrected_codeword_o;
    logic         error_detected_o;
    logic         uncorrectable_o;

    modport master (
        output enc_valid_i, msg_i, dec_valid_i, rx_codeword_i,
        input  enc_valid_o, codeword_o, dec_valid_o, corrected_codeword_o,
               error_detected_o, uncorrectable_o
    );

    modport slave (
        input  enc_valid_i, msg_i, dec_valid_i, rx_codeword_i,
        output enc_valid_o, codeword_o, dec_valid_o, corrected_codeword_o,
               error_detected_o, uncorrectable_o
    );

endinterface

// File: rtl/bch_31_21_decoder_core.sv
// rtl/bch_31_21_decoder_core.sv - two-stage syndrome / locator / Chien-search decoder
module bch_31_21_decoder_core
    import bch_31_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [N-1:0] rx_i,
    output logic         valid_o,
    output logic [N-1:0] corrected_o,
    output logic         err_o,
    output logic         uncorr_o
);

    logic         v1_q, v1_d;
    logic [N-1:0] rx1_q, rx1_d;
    logic [4:0]   s1_q, s1_d, s3_q, s3_d;

    logic         v2_q, v2_d;
    logic [N-1:0] cor_q, cor_d;
    logic         err_q, err_d;
    logic         unc_q, unc_d;

    logic [4:0]   s1_cube, sigma2, x;
    logic [N-1:0] flip;
    logic [5:0]   root_cnt;

    // Stage 1: each syndrome is an XOR of constant alpha-power columns selected by rx bits
    always_comb begin
        v1_d  = valid_i;
        rx1_d = rx1_q;
        s1_d  = s1_q;
        s3_d  = s3_q;
        if (valid_i) begin
            rx1_d = rx_i;
            s1_d  = '0;
            s3_d  = '0;
            for (int j = 0; j < N; j++) begin
                if (rx_i[5'(j)]) begin
                    s1_d = s1_d ^ GF_EXP[5'(j)];
                    s3_d = s3_d ^ GF_EXP[5'((3 * j) % N)];
                end
            end
        end
    end

    // Stage 2: sigma(x) = 1 + S1 x + sigma2 x^2, roots tested at alpha^-j for every bit j
    always_comb begin
        s1_cube  = gf_pow3(s1_q);
        sigma2   = gf_mul(s3_q ^ s1_cube, gf_inv(s1_q));
        flip     = '0;
        root_cnt = '0;
        x        = '0;
        for (int j = 0; j < N; j++) begin
            x = GF_EXP[5'((N - j) % N)];
            if ((5'd1 ^ gf_mul(s1_q, x) ^ gf_mul(sigma2, gf_mul(x, x))) == 5'd0) begin
                flip[5'(j)] = 1'b1;
                root_cnt    = root_cnt + 6'd1;
            end
        end

        v2_d  = v1_q;
        cor_d = cor_q;
        err_d = err_q;
        unc_d = unc_q;
        if (v1_q) begin
            cor_d = rx1_q;
            err_d = (s1_q != 5'd0) || (s3_q != 5'd0);
            unc_d = 1'b0;
            if (s1_q != 5'd0) begin
                if (s3_q == s1_cube) begin
                    cor_d[GF_LOG[s1_q]] = ~rx1_q[GF_LOG[s1_q]];
                end else if (root_cnt == 6'(T)) begin
                    cor_d = rx1_q ^ flip;
                end else begin
                    unc_d = 1'b1;
                end
            end else if (s3_q != 5'd0) begin
                unc_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            rx1_q <= '0;
            s1_q  <= '0;
            s3_q  <= '0;
            v2_q  <= 1'b0;
            cor_q <= '0;
            err_q <= 1'b0;
            unc_q <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            rx1_q <= rx1_d;
            s1_q  <= s1_d;
            s3_q  <= s3_d;
            v2_q  <= v2_d;
            cor_q <= cor_d;
            err_q <= err_d;
            unc_q <= unc_d;
        end
    end

    assign valid_o     = v2_q;
    assign corrected_o = cor_q;
    assign err_o       = err_q;
    assign uncorr_o    = unc_q;

endmodule

// File: rtl/bch_31_21_codec.sv
// rtl/bch_31_21_codec.sv - BCH(31,21) t=2 codec: 1-cycle systematic encoder, 2-cycle decoder
module bch_31_21_codec
    import bch_31_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    bch_31_21_codec_if.slave    bus
);

    logic         enc_valid_q, enc_valid_d;
    logic [N-1:0] codeword_q, codeword_d;

    // Remainder of m(x)*x^10 divided by g(x), one message bit per division step
    function automatic logic [NK-1:0] enc_parity(input logic [K-1:0] m);
        logic [NK-1:0] r;
        logic          fb;
        r = '0;
        for (int i = K - 1; i >= 0; i--) begin
            fb = m[5'(i)] ^ r[NK-1];
            r  = {r[NK-2:0], 1'b0};
            if (fb) r = r ^ GEN_POLY[NK-1:0];
        end
        return r;
    endfunction

    always_comb begin
        enc_valid_d = bus.enc_valid_i;
        codeword_d  = codeword_q;
        if (bus.enc_valid_i) codeword_d = {bus.msg_i, enc_parity(bus.msg_i)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_valid_q <= 1'b0;
            codeword_q  <= '0;
        end else begin
            enc_valid_q <= enc_valid_d;
            codeword_q  <= codeword_d;
        end
    end

    assign bus.enc_valid_o = enc_valid_q;
    assign bus.codeword_o  = codeword_q;

    bch_31_21_decoder_core u_dec (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (bus.dec_valid_i),
        .rx_i        (bus.rx_codeword_i),
        .valid_o     (bus.dec_valid_o),
        .corrected_o (bus.corrected_codeword_o),
        .err_o       (bus.error_detected_o),
        .uncorr_o    (bus.uncorrectable_o)
    );

endmodule

// File: tb/tb_bch_31_21_codec.sv
// tb/tb_bch_31_21_codec.sv - randomized self-checking bench for bch_31_21_codec
module tb_bch_31_21_codec;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    bch_31_21_codec_if bus ();

    bch_31_21_codec dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [30:0] rx;
        logic [30:0] orig;
        bit          three;
    } rec_t;

    rec_t        pend[$];
    logic [30:0] exp_cw;

    // Polynomial remainder of a(x) modulo g(x) by schoolbook long division
    function automatic logic [9:0] poly_mod(input logic [30:0] a);
        logic [30:0] g;
        g = 31'h769;
        for (int d = 30; d >= 10; d--) begin
            if (a[d]) a = a ^ (g << (d - 10));
        end
        return a[9:0];
    endfunction

    function automatic logic [30:0] enc_model(input logic [20:0] m);
        logic [30:0] shifted;
        shifted = {m, 10'b0};
        return shifted | 31'(poly_mod(shifted));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_enc_valid"}, 32'(bus.enc_valid_o), 0);
        chk({tag, "_codeword"}, 32'(bus.codeword_o), 0);
        chk({tag, "_dec_valid"}, 32'(bus.dec_valid_o), 0);
        chk({tag, "_corrected"}, 32'(bus.corrected_codeword_o), 0);
        chk({tag, "_err"}, 32'(bus.error_detected_o), 0);
        chk({tag, "_unc"}, 32'(bus.uncorrectable_o), 0);
    endtask

    task automatic check_dec(input rec_t r);
        logic ok;
        chk("dec_valid", 32'(bus.dec_valid_o), 32'(r.v));
        if (r.v) begin
            if (!r.three) begin
                chk("corrected", 32'(bus.corrected_codeword_o), 32'(r.orig));
                chk("err_det", 32'(bus.error_detected_o), 32'(r.rx != r.orig));
                chk("uncorr", 32'(bus.uncorrectable_o), 0);
            end else begin
                chk("three_err_det", 32'(bus.error_detected_o), 1);
                if (bus.uncorrectable_o)
                    ok = (bus.corrected_codeword_o == r.rx);
                else
                    ok = (poly_mod(bus.corrected_codeword_o) == 10'd0) &&
                         ($countones(bus.corrected_codeword_o ^ r.rx) <= 2);
                chk("three_outcome", 32'(ok), 1);
            end
        end
    endtask

    // One clock: drive both paths, check encoder at latency 1 and decoder at latency 2
    task automatic step(input logic ev, input logic [20:0] m, input logic dv,
                        input logic [30:0] rx, input logic [30:0] orig, input bit three);
        rec_t r;
        bus.enc_valid_i   = ev;
        bus.msg_i         = m;
        bus.dec_valid_i   = dv;
        bus.rx_codeword_i = rx;
        r.v = dv; r.rx = rx; r.orig = orig; r.three = three;
        pend.push_back(r);
        if (ev) exp_cw = enc_model(m);
        @(posedge clk); #1;
        chk("enc_valid", 32'(bus.enc_valid_o), 32'(ev));
        chk("enc_cw", 32'(bus.codeword_o), 32'(exp_cw));
        if (pend.size() == 2) check_dec(pend.pop_front());
    endtask

    task automatic apply_reset(input int cycles, input string tag);
        rst_n             = 1'b0;
        bus.enc_valid_i   = 1'b1;
        bus.msg_i         = 21'($urandom);
        bus.dec_valid_i   = 1'b1;
        bus.rx_codeword_i = 31'($urandom);
        repeat (cycles) @(posedge clk);
        #1;
        check_zero(tag);
        rst_n = 1'b1;
        pend.delete();
        exp_cw = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [20:0] m;
        logic [30:0] cw, e;
        int          p0, p1, p2;
        n_tests = 0;
        n_fail  = 0;
        exp_cw  = '0;

        apply_reset(3, "rst");
        step(1'b1, 21'h000000, 1'b0, '0, '0, 1'b0);
        chk("enc_zero_const", 32'(bus.codeword_o), 32'h0);
        step(1'b1, 21'h000001, 1'b0, '0, '0, 1'b0);
        chk("enc_one_const", 32'(bus.codeword_o), 32'h0000_0769);
        step(1'b1, 21'h1FFFFF, 1'b0, '0, '0, 1'b0);
        chk("enc_ones_const", 32'(bus.codeword_o), 32'h7FFF_FFFF);

        cw = enc_model(21'h155555);
        step(1'b0, '0, 1'b1, 31'h7FFFFFFF, 31'h7FFFFFFF, 1'b0);
        step(1'b0, '0, 1'b1, cw ^ 31'h1, cw, 1'b0);
        step(1'b0, '0, 1'b1, 31'h7FFFFFFF ^ 31'h6, 31'h7FFFFFFF, 1'b0);

        // Back-to-back sweep of every 1- and 2-bit error, encoder driven at random alongside
        for (int t = 0; t < 3; t++) begin
            m  = 21'($urandom);
            cw = enc_model(m);
            step(1'($urandom), 21'($urandom), 1'b1, cw, cw, 1'b0);
            for (int i = 0; i < 31; i++) begin
                step(1'($urandom), 21'($urandom), 1'b1, cw ^ (31'h1 << i), cw, 1'b0);
            end
            for (int i = 0; i < 31; i++) begin
                for (int j = i + 1; j < 31; j++) begin
                    e = (31'h1 << i) | (31'h1 << j);
                    step(1'($urandom), 21'($urandom), 1'b1, cw ^ e, cw, 1'b0);
                end
            end
        end

        for (int t = 0; t < 60; t++) begin
            cw = enc_model(21'($urandom));
            p0 = $urandom_range(0, 30);
            do p1 = $urandom_range(0, 30); while (p1 == p0);
            do p2 = $urandom_range(0, 30); while (p2 == p0 || p2 == p1);
            e = (31'h1 << p0) | (31'h1 << p1) | (31'h1 << p2);
            step(1'b0, '0, 1'($urandom), cw ^ e, cw, 1'b1);
        end

        cw = enc_model(21'($urandom));
        step(1'b1, 21'($urandom), 1'b1, cw ^ 31'h10, cw, 1'b0);
        apply_reset(1, "midrst");
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bch_31_21_codec.md
Name: bch_31_21_codec

Overview:
Binary BCH(31,21) codec with t=2, built over GF(2^5) with primitive polynomial x^5+x^2+1.
- Encoder path: systematically encodes a 21-bit message into a 31-bit codeword.
- Decoder path: takes a received (possibly corrupted) 31-bit word, detects errors and corrects up to 2 bit errors.
- Used as the error-protection stage between message producers and the storage/link channel.

Parameters:
- None. The code is fixed: n=31, k=21, t=2, generator g(x)=x^10+x^9+x^8+x^6+x^5+x^3+1 (0x769).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- enc_valid_i  input  1  msg_i valid this cycle
- msg_i  input  21  message; bit j = coefficient of x^(j+10) in the codeword
- enc_valid_o  output  1  codeword_o valid
- codeword_o  output  31  systematic codeword
- dec_valid_i  input  1  rx_codeword_i valid this cycle
- rx_codeword_i  input  31  received word; bit j = coefficient of x^j
- dec_valid_o  output  1  decoder outputs valid
- corrected_codeword_o  output  31  corrected word
- error_detected_o  output  1  nonzero syndrome
- uncorrectable_o  output  1  more than 2 errors detected

Behaviour:
- Reset: a rising clk edge with rst_n=0 clears every output register to 0. A reset mid-pipeline discards in-flight data; valids stay 0 until new input arrives.
- Encoder (latency 1):
  - codeword_o[30:10] = msg_i.
  - codeword_o[9:0] = (msg_i·x^10) mod g(x).
  - Registered together with enc_valid_o.
  - Registers update only when enc_valid_i=1; enc_valid_o is set to enc_valid_i every cycle.
- Decoder (latency 2, fully pipelined, one word per cycle, no backpressure):
  - Stage 1 registers the received word, S1 = r(α) and S3 = r(α^3). Each syndrome is a 5-bit GF element, computed as an XOR of constant α-power columns.
  - Stage 2 registers the outputs.
- Stage 2 cases:
  - S1=0, S3=0: no error. Output = received word; error_detected_o=0, uncorrectable_o=0.
  - S1≠0, S3=S1^3: single error at position i where α^i=S1. Flip bit i; error_detected_o=1.
  - S1≠0, S3≠S1^3: locator σ(x)=1+S1·x+σ2·x^2 with σ2=(S3+S1^3)·S1^-1. Chien search over j=0..30 flips bit j when σ(α^-j)=0. If the root count is not 2, set uncorrectable_o=1 and pass the received word through unflipped. error_detected_o=1.
  - S1=0, S3≠0: uncorrectable_o=1, error_detected_o=1, pass-through.
- Correction never flips more than 2 bits.
- Patterns with 3 or more errors either raise uncorrectable_o or miscorrect to a valid codeword. Both outcomes are allowed.
- The encoder and decoder paths are independent; simultaneous valids on both are legal.
- GF arithmetic: multiply is a polynomial product reduced by x^5+x^2+1; inverse is a 31-entry constant lookup; 0 has no inverse and is never inverted.

Decomposition:
- Package bch_31_pkg holds:
  - N/K/T constants and GEN_POLY = 11'h769
  - the GF(32) α-power table and its log/inverse tables
  - functions gf_mul, gf_inv, gf_pow3
- One sub-module is natural: bch_31_21_decoder_core (syndrome, locator and Chien stages). The encoder stays inline as combinational parity logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with valids high -> all outputs 0. Release with enc_valid_i=1, msg_i=0 -> one cycle later codeword_o=0, enc_valid_o=1.
- Encoder:
  - msg_i=21'h000001 -> codeword_o=31'h00000769.
  - msg_i=21'h1FFFFF -> codeword_o=31'h7FFFFFFF.
- Clean decode: rx=31'h7FFFFFFF -> two cycles later corrected=31'h7FFFFFFF, error_detected_o=0, uncorrectable_o=0, dec_valid_o=1.
- Single and double errors:
  - codeword of msg 21'h155555 XOR 31'h1 -> corrected equals that codeword; error_detected_o=1.
  - 31'h7FFFFFFF XOR 31'h6 -> corrected=31'h7FFFFFFF, error_detected_o=1, uncorrectable_o=0.
- Exhaustive: for random messages, sweep all 31 single-bit and all 465 double-bit error patterns -> always corrected, uncorrectable_o=0.
- Back-to-back and three errors:
  - dec_valid_i held high with a new word every cycle -> outputs stream in order at latency 2.
  - 3-bit errors -> error_detected_o=1, and either uncorrectable_o=1 with pass-through, or a valid codeword at Hamming distance ≤2 from rx.
